// File: rtl/aap_exec_pkg.sv
// aap_exec_pkg: opcodes, FSM states, shifter modes and opcode predicates
// shared by the AAP execute unit and its iterative shifter.
// Optional multiplier support is selected by AAP_EXEC_MUL_EN.
package aap_exec_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = $clog2(DATA_W_DEF + 1);

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,
        OP_OR   = 5'd4,  OP_XOR  = 5'd5,  OP_ASR  = 5'd6,  OP_LSL  = 5'd7,
        OP_LSR  = 5'd8,  OP_MOV  = 5'd9,  OP_ADDI = 5'd10, OP_SUBI = 5'd11,
        OP_ASRI = 5'd12, OP_LSLI = 5'd13, OP_LSRI = 5'd14, OP_MOVI = 5'd15,
        OP_ADC  = 5'd16, OP_SBC  = 5'd17, OP_MUL  = 5'd18
    } opcode_e;

    typedef enum logic [2:0] {IDLE, READ, EXEC, SHIFT, WRITE} state_e;

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_MUL} sh_mode_e;

    // Immediate forms take B from the zero-extended immediate.
    function automatic logic is_imm(input logic [4:0] op);
        return (op >= 5'd10) && (op <= 5'd15);
    endfunction

    function automatic logic is_shift(input logic [4:0] op);
        return (op == 5'd6) || (op == 5'd7) || (op == 5'd8) ||
               (op == 5'd12) || (op == 5'd13) || (op == 5'd14);
    endfunction

    function automatic logic writes_reg(input logic [4:0] op);
`ifdef AAP_EXEC_MUL_EN
        return (op >= 5'd1) && (op <= 5'd18);
`else
        return (op >= 5'd1) && (op <= 5'd17);
`endif
    endfunction

endpackage

// File: rtl/aap_exec_if.sv
// aap_exec_if: decode handshake plus register-file read/write bus of the
// AAP execute unit. slave = the unit, master = decode/register file side.
interface aap_exec_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 6,
    parameter int IMM_W  = 10,
    parameter int OP_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [IMM_W-1:0]  imm;
    logic [REG_AW-1:0] rd1_addr;
    logic [REG_AW-1:0] rd2_addr;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              carry;
    logic              busy;

    modport slave (
        input  in_valid, op, dst, src1, src2, imm, rd1_data, rd2_data,
        output in_ready, rd1_addr, rd2_addr, wr_addr, wr_data, wr_en, carry, busy
    );

    modport master (
        output in_valid, op, dst, src1, src2, imm, rd1_data, rd2_data,
        input  in_ready, rd1_addr, rd2_addr, wr_addr, wr_data, wr_en, carry, busy
    );
endinterface

// File: rtl/aap_exec_shifter.sv
// aap_exec_shifter: one-bit-per-cycle shifter. Loaded on start_i, steps while
// the count is non-zero; res_o/done_o describe the step taken this cycle.
// With AAP_EXEC_MUL_EN the same register doubles as the low half of an
// unsigned shift-add multiplier (SH_MUL).
module aap_exec_shifter
    import aap_exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CW     = CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  sh_mode_e          mode_i,
    input  logic [CW-1:0]     cnt_i,
    input  logic [DATA_W-1:0] val_i,
`ifdef AAP_EXEC_MUL_EN
    input  logic [DATA_W-1:0] mcand_i,
    output logic              hi_nz_o,
`endif
    output logic [DATA_W-1:0] res_o,
    output logic              done_o
);
    sh_mode_e          mode_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] val_q, val_d;
`ifdef AAP_EXEC_MUL_EN
    logic [DATA_W-1:0] mcand_q, hi_q, hi_d;
    logic [DATA_W:0]   sum;
`endif

    // Value after one step in the current mode.
    always_comb begin
        val_d = val_q;
`ifdef AAP_EXEC_MUL_EN
        hi_d  = hi_q;
        sum   = {1'b0, hi_q} + (val_q[0] ? {1'b0, mcand_q} : '0);
`endif
        case (mode_q)
            SH_LSL:  val_d = {val_q[DATA_W-2:0], 1'b0};
            SH_LSR:  val_d = {1'b0, val_q[DATA_W-1:1]};
            SH_ASR:  val_d = {val_q[DATA_W-1], val_q[DATA_W-1:1]};
            default: begin
`ifdef AAP_EXEC_MUL_EN
                // {hi,lo} shifts right; add carry-out enters the top of hi.
                hi_d  = sum[DATA_W:1];
                val_d = {sum[0], val_q[DATA_W-1:1]};
`endif
            end
        endcase
    end

    // Load on start, then step and count down until the count is exhausted.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q <= SH_LSL;
            cnt_q  <= '0;
            val_q  <= '0;
`ifdef AAP_EXEC_MUL_EN
            mcand_q <= '0;
            hi_q    <= '0;
`endif
        end else if (start_i) begin
            mode_q <= mode_i;
            cnt_q  <= cnt_i;
            val_q  <= val_i;
`ifdef AAP_EXEC_MUL_EN
            mcand_q <= mcand_i;
            hi_q    <= '0;
`endif
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            val_q <= val_d;
`ifdef AAP_EXEC_MUL_EN
            hi_q  <= hi_d;
`endif
        end
    end

    assign res_o  = val_d;
    assign done_o = (cnt_q == CW'(1));
`ifdef AAP_EXEC_MUL_EN
    assign hi_nz_o = |hi_d;
`endif

endmodule

// File: rtl/aap_exec_unit.sv
// aap_exec_unit: handshaked AAP execute stage. Accepts a decoded op, reads
// both operands from the register file, computes (iteratively for shifts)
// and issues one register-file write. Define AAP_EXEC_MUL_EN to add op 18 MUL.
module aap_exec_unit
    import aap_exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 6,
    parameter int IMM_W  = 10,
    parameter int OP_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    aap_exec_if.slave  bus
);
    localparam int                CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]     CNT_FULL = CW'(DATA_W);
    localparam logic [DATA_W-1:0] W_LIM    = DATA_W'(DATA_W);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] dst_q, rd1_q, rd2_q, wr_addr_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] a_q, b_q, wr_data_q, alu_r, wr_val, sh_res, sh_val;
    logic [DATA_W:0]   sum;
    logic              carry_q, alu_cu, c_val, upd_c, load_wr;
    logic              is_mul, is_sh, sh_start, sh_done, sh_hi_nz;
    logic [CW-1:0]     sh_cnt;
    sh_mode_e          sh_mode;

`ifdef AAP_EXEC_MUL_EN
    assign is_mul = (op_q == OP_MUL);
`else
    assign is_mul   = 1'b0;
    assign sh_hi_nz = 1'b0;
`endif
    assign is_sh  = is_shift(op_q) || is_mul;
    assign sh_cnt = is_mul ? CNT_FULL : ((b_q >= W_LIM) ? CNT_FULL : b_q[CW-1:0]);
    assign sh_val = is_mul ? b_q : a_q;

    // Single-cycle ALU, DATA_W+1 bits wide so bit DATA_W is carry/borrow.
    always_comb begin
        sum    = '0;
        alu_cu = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI: begin sum = {1'b0, a_q} + {1'b0, b_q}; alu_cu = 1'b1; end
            OP_ADC:  begin sum = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, carry_q}; alu_cu = 1'b1; end
            OP_SUB, OP_SUBI: begin sum = {1'b0, a_q} - {1'b0, b_q}; alu_cu = 1'b1; end
            OP_SBC:  begin sum = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, carry_q}; alu_cu = 1'b1; end
            OP_AND:  sum = {1'b0, a_q & b_q};
            OP_OR:   sum = {1'b0, a_q | b_q};
            OP_XOR:  sum = {1'b0, a_q ^ b_q};
            OP_MOV:  sum = {1'b0, a_q};
            OP_MOVI: sum = {1'b0, b_q};
            default: sum = '0;
        endcase
        alu_r = sum[DATA_W-1:0];
    end

    // Shifter mode selected from the latched opcode.
    always_comb begin
        sh_mode = SH_LSL;
        case (op_q)
            OP_ASR, OP_ASRI: sh_mode = SH_ASR;
            OP_LSR, OP_LSRI: sh_mode = SH_LSR;
            OP_MUL:          sh_mode = SH_MUL;
            default:         sh_mode = SH_LSL;
        endcase
    end

    aap_exec_shifter #(.DATA_W(DATA_W), .CW(CW)) u_shift (
        .clock   (clock),
        .reset   (reset),
        .start_i (sh_start),
        .mode_i  (sh_mode),
        .cnt_i   (sh_cnt),
        .val_i   (sh_val),
`ifdef AAP_EXEC_MUL_EN
        .mcand_i (a_q),
        .hi_nz_o (sh_hi_nz),
`endif
        .res_o   (sh_res),
        .done_o  (sh_done)
    );

    // Next state plus write/carry load controls.
    always_comb begin
        state_d  = state_q;
        sh_start = 1'b0;
        load_wr  = 1'b0;
        wr_val   = alu_r;
        upd_c    = 1'b0;
        c_val    = sum[DATA_W];
        case (state_q)
            IDLE:  if (bus.in_valid) state_d = READ;
            READ:  state_d = EXEC;
            EXEC: begin
                if (is_sh) begin
                    if (sh_cnt == '0) begin
                        // Zero-length shift: result is A unchanged.
                        state_d = WRITE;
                        load_wr = 1'b1;
                        wr_val  = a_q;
                    end else begin
                        state_d  = SHIFT;
                        sh_start = 1'b1;
                    end
                end else if (writes_reg(op_q)) begin
                    state_d = WRITE;
                    load_wr = 1'b1;
                    upd_c   = alu_cu;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: if (sh_done) begin
                state_d = WRITE;
                load_wr = 1'b1;
                wr_val  = sh_res;
                upd_c   = is_mul;
                c_val   = sh_hi_nz;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operand capture, write-port registers and architectural carry.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.in_valid) begin
                op_q  <= bus.op;
                dst_q <= bus.dst;
                imm_q <= bus.imm;
                rd1_q <= bus.src1;
                rd2_q <= bus.src2;
            end
            if (state_q == READ) begin
                a_q <= bus.rd1_data;
                b_q <= is_imm(op_q) ? {{(DATA_W-IMM_W){1'b0}}, imm_q} : bus.rd2_data;
            end
            if (load_wr) begin
                wr_addr_q <= dst_q;
                wr_data_q <= wr_val;
            end
            if (upd_c) carry_q <= c_val;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.wr_en    = (state_q == WRITE) && !reset;
    assign bus.rd1_addr = rd1_q;
    assign bus.rd2_addr = rd2_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.carry    = carry_q;

endmodule

// File: tb/tb_aap_exec_unit.sv
// tb_aap_exec_unit: directed plus randomized stimulus; an arithmetic reference
// model pushes expected writes into a queue, a forked monitor pops and checks.
module tb_aap_exec_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    aap_exec_if #(.DATA_W(16), .REG_AW(6), .IMM_W(10), .OP_W(5)) bus ();

    aap_exec_unit #(.DATA_W(16), .REG_AW(6), .IMM_W(10), .OP_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] rf [64];
    assign bus.rd1_data = rf[bus.rd1_addr];
    assign bus.rd2_data = rf[bus.rd2_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int carry;
        int lat;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_wr   = 0;
    int   mcarry = 0;
    int   last_c = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Reference model: returns 1 if the op writes, with result, carry-out, latency.
    function automatic bit model(input int o, input int a, input int breg, input int im,
                                 input int cin, output int r, output int co, output int lat);
        int  b, n, sa;
        longint p;
        b   = (o >= 10 && o <= 15) ? im : breg;
        co  = cin;
        lat = 3;
        r   = 0;
        case (o)
            1, 10: begin r = a + b; co = (r >> 16) & 1; r = r & 'hFFFF; end
            16:    begin r = a + b + cin; co = (r >> 16) & 1; r = r & 'hFFFF; end
            2, 11: begin co = (a < b) ? 1 : 0; r = (a - b) & 'hFFFF; end
            17:    begin co = (a < b + cin) ? 1 : 0; r = (a - b - cin) & 'hFFFF; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            9: r = a;
            15: r = b;
            6, 7, 8, 12, 13, 14: begin
                n   = (b > 16) ? 16 : b;
                lat = 3 + n;
                sa  = (a >= 32768) ? a - 65536 : a;
                if (o == 6 || o == 12)      r = ((n >= 16) ? (sa >>> 15) : (sa >>> n)) & 'hFFFF;
                else if (o == 7 || o == 13) r = (n >= 16) ? 0 : ((a << n) & 'hFFFF);
                else                        r = (n >= 16) ? 0 : (a >> n);
            end
`ifdef AAP_EXEC_MUL_EN
            18: begin
                p   = longint'(a) * longint'(b);
                r   = int'(p & 'hFFFF);
                co  = ((p >> 16) != 0) ? 1 : 0;
                lat = 19;
            end
`endif
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Called at a negedge; holds in_valid until accepted, then optionally drops it.
    task automatic issue(input int o, input int d, input int s1, input int s2,
                         input int im, input bit hold);
        bit acc;
        int r, co, lat;
        bus.in_valid = 1'b1;
        bus.op   = 5'(o);
        bus.dst  = 6'(d);
        bus.src1 = 6'(s1);
        bus.src2 = 6'(s2);
        bus.imm  = 10'(im);
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            if (bus.in_ready) begin
                acc    = 1'b1;
                last_c = cyc;
                if (model(o, int'(rf[s1]), int'(rf[s2]), im, mcarry, r, co, lat)) begin
                    mcarry = co;
                    exp_q.push_back('{d, r, co, lat, cyc});
                end
            end
            @(negedge clock);
        end
        if (!acc) chk("accept_timeout", 0, 1);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (bus.in_ready && exp_q.size() == 0) ok = 1'b1;
            else @(negedge clock);
        end
        if (!ok) chk("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.wr_en) begin
                n_wr++;
                if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", bus.wr_addr, e.addr);
                    chk("wr_data", bus.wr_data, e.data);
                    chk("carry",   bus.carry,   e.carry);
                    chk("latency", cyc - e.c,   e.lat);
                end
            end
        end
    endtask

    initial begin
        int w0, c0, o;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.op   = '0;
        bus.dst  = '0;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.imm  = '0;
        for (int i = 0; i < 64; i++) rf[i] = '0;
        fork monitor(); join_none
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_wr_en",    bus.wr_en,    0);
        chk("rst_carry",    bus.carry,    0);
        chk("rst_rd_addr",  {bus.rd1_addr, bus.rd2_addr}, 0);
        chk("rst_wr_port",  {bus.wr_addr, bus.wr_data},   0);

        rf[1] = 16'hFFFF; rf[2] = 16'h0001;
        issue(1, 3, 1, 2, 0, 0);            // ADD: 0x0000, carry 1
        wait_idle();
        rf[1] = 16'h0000; rf[2] = 16'h0000;
        issue(16, 4, 1, 2, 0, 0);           // ADC with cin=1: 0x0001, carry 0
        wait_idle();
        rf[1] = 16'h0005;
        issue(11, 5, 1, 0, 7, 0);           // SUBI: 0xFFFE, borrow 1
        wait_idle();
        rf[1] = 16'h8000; rf[2] = 16'd4;
        issue(6, 6, 1, 2, 0, 0);            // ASR 4: 0xF800 at cycle 7
        wait_idle();
        rf[2] = 16'd20;
        issue(6, 6, 1, 2, 0, 0);            // ASR 20: 0xFFFF at cycle 19
        wait_idle();
        rf[2] = 16'd0;
        issue(7, 9, 1, 2, 0, 0);            // LSL 0: passes straight to WRITE
        wait_idle();
        rf[1] = 16'hA5C3;
        issue(14, 10, 1, 0, 3, 0);          // LSRI 3
        wait_idle();

        // Undefined op: no write, back in IDLE at cycle 3.
        w0 = n_wr;
        issue(25, 7, 1, 2, 0, 0);
        c0 = last_c;
        while (cyc < c0 + 2) @(negedge clock);
        chk("undef_busy_c2",  bus.in_ready, 0);
        @(negedge clock);
        chk("undef_idle_c3",  bus.in_ready, 1);
        chk("undef_no_write", n_wr - w0, 0);

`ifdef AAP_EXEC_MUL_EN
        rf[1] = 16'h0100; rf[2] = 16'h0100;
        issue(18, 11, 1, 2, 0, 0);          // MUL: 0x0000, carry 1
        wait_idle();
`endif

        // Reset in the middle of an LSL by 10 aborts the write and clears carry.
        rf[1] = 16'hFFFF; rf[2] = 16'h0001;
        issue(1, 12, 1, 2, 0, 0);
        wait_idle();
        rf[1] = 16'h0003; rf[2] = 16'd10;
        w0 = n_wr;
        issue(7, 13, 1, 2, 0, 0);
        repeat (4) @(negedge clock);
        chk("carry_before_rst", bus.carry, 1);
        reset = 1'b1;
        exp_q.delete();
        mcarry = 0;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_carry",    bus.carry,    0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_busy",     bus.busy,     0);
        repeat (15) @(negedge clock);
        chk("abort_no_write", n_wr - w0, 0);

        // Randomized back-to-back stream with in_valid held high.
        for (int i = 0; i < 64; i++)
            rf[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
        for (int k = 0; k < 40; k++) begin
            o = ($urandom_range(0, 7) == 0) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
            issue(o, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)), k != 39);
        end
        wait_idle();
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
